// File: rtl/noc_pkg.sv
// Shared router definitions: port indices, select encoding, allocator states.
// Used by switch_allocator and rr_arbiter.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    typedef logic [2:0] port_sel_t;

    localparam port_sel_t SEL_IDLE = 3'b111;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_S = 3'd1,
        PORT_W = 3'd2,
        PORT_E = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } out_state_e;

    // Round-robin successor, wrapping from the last port back to 0.
    function automatic port_sel_t rr_next(input port_sel_t p);
        return (p == port_sel_t'(NUM_PORTS - 1)) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr_i, wrapping.
// Ports: req_i[4:0] requests, ptr_i[2:0] start index, gnt_o[4:0] one-hot grant.
module rr_arbiter
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [2:0]           ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    always_comb begin
        logic       found;
        logic [3:0] sum;
        logic [2:0] idx;
        gnt_o = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, ptr_i} + 4'(k);
            if (sum >= 4'(NUM_PORTS)) begin
                sum = sum - 4'(NUM_PORTS);
            end
            idx = sum[2:0];
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator for a 5-port router: one lock FSM per output.
// Inputs: clk_i, rst_ni (sync, active-low), req_i/dest_i/tail_i per input,
// out_ready_i per output. Outputs: grant_o, xfer_o, sel_demux_o (per input),
// sel_mux_o, timeout_o (per output). Optional macro SW_ALLOC_TIMEOUT_EN adds
// a per-output stall counter that force-releases a stuck lock.
module switch_allocator #(
    parameter int NUM_PORTS   = 5,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NUM_PORTS-1:0]   req_i,
    input  logic [3*NUM_PORTS-1:0] dest_i,
    input  logic [NUM_PORTS-1:0]   tail_i,
    input  logic [NUM_PORTS-1:0]   out_ready_i,
    output logic [NUM_PORTS-1:0]   grant_o,
    output logic [NUM_PORTS-1:0]   xfer_o,
    output logic [3*NUM_PORTS-1:0] sel_demux_o,
    output logic [3*NUM_PORTS-1:0] sel_mux_o,
    output logic [NUM_PORTS-1:0]   timeout_o
);

    import noc_pkg::*;

    out_state_e           state_q [NUM_PORTS];
    out_state_e           state_d [NUM_PORTS];
    port_sel_t            own_q   [NUM_PORTS];
    port_sel_t            own_d   [NUM_PORTS];
    port_sel_t            rr_q    [NUM_PORTS];
    port_sel_t            rr_d    [NUM_PORTS];
    port_sel_t            mux_q   [NUM_PORTS];
    port_sel_t            mux_d   [NUM_PORTS];
    port_sel_t            dmx_q   [NUM_PORTS];
    port_sel_t            dmx_d   [NUM_PORTS];
    logic [NUM_PORTS-1:0] gnt_q;
    logic [NUM_PORTS-1:0] gnt_d;

    port_sel_t            dest    [NUM_PORTS];
    logic [NUM_PORTS-1:0] cand    [NUM_PORTS];
    logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
    port_sel_t            win     [NUM_PORTS];
    logic [NUM_PORTS-1:0] xfer;
    logic [NUM_PORTS-1:0] out_xfer;
    logic [NUM_PORTS-1:0] out_tail;

`ifdef SW_ALLOC_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
    logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] to_q;
    logic [NUM_PORTS-1:0] to_d;
`endif

    // Candidate matrix: an input competes for its destination only when it
    // holds no lock and is not routing back to itself. Out-of-range
    // destinations (5..7) match no output and so are silently ignored.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            dest[p] = dest_i[3*p +: 3];
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            cand[o] = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                cand[o][p] = req_i[p] && !gnt_q[p]
                          && (dest[p] == port_sel_t'(o))
                          && (dest[p] != port_sel_t'(p));
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter u_arb (
            .req_i (cand[o]),
            .ptr_i (rr_q[o]),
            .gnt_o (arb_gnt[o])
        );
    end

    // Transfer strobes, plus per-output views of the owner's xfer/tail and
    // the encoded arbitration winner.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            xfer[p] = 1'b0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (dmx_q[p] == port_sel_t'(o)) begin
                    xfer[p] = gnt_q[p] & req_i[p] & out_ready_i[o];
                end
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_xfer[o] = 1'b0;
            out_tail[o] = 1'b0;
            win[o]      = SEL_IDLE;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (own_q[o] == port_sel_t'(p)) begin
                    out_xfer[o] = xfer[p];
                    out_tail[o] = tail_i[p];
                end
                if (arb_gnt[o][p]) begin
                    win[o] = port_sel_t'(p);
                end
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            own_d[o]   = own_q[o];
            rr_d[o]    = rr_q[o];
`ifdef SW_ALLOC_TIMEOUT_EN
            cnt_d[o]   = cnt_q[o];
            to_d[o]    = 1'b0;
`endif
            unique case (state_q[o])
                ST_IDLE: begin
`ifdef SW_ALLOC_TIMEOUT_EN
                    cnt_d[o] = '0;
`endif
                    if (|arb_gnt[o]) begin
                        state_d[o] = ST_LOCKED;
                        own_d[o]   = win[o];
                        rr_d[o]    = rr_next(win[o]);
                    end
                end
                ST_LOCKED: begin
`ifdef SW_ALLOC_TIMEOUT_EN
                    if (out_xfer[o]) begin
                        cnt_d[o] = '0;
                        if (out_tail[o]) begin
                            state_d[o] = ST_IDLE;
                            own_d[o]   = SEL_IDLE;
                        end
                    end else if (cnt_q[o] == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Stalled too long: drop the lock without a tail.
                        state_d[o] = ST_IDLE;
                        own_d[o]   = SEL_IDLE;
                        cnt_d[o]   = '0;
                        to_d[o]    = 1'b1;
                    end else begin
                        cnt_d[o] = cnt_q[o] + 1'b1;
                    end
`else
                    if (out_xfer[o] && out_tail[o]) begin
                        state_d[o] = ST_IDLE;
                        own_d[o]   = SEL_IDLE;
                    end
`endif
                end
                default: begin
                    state_d[o] = ST_IDLE;
                    own_d[o]   = SEL_IDLE;
                end
            endcase
        end

        // Per-input grant/demux and per-output mux follow the next lock state
        // so every select is a plain register output.
        for (int p = 0; p < NUM_PORTS; p++) begin
            gnt_d[p] = 1'b0;
            dmx_d[p] = SEL_IDLE;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            mux_d[o] = (state_d[o] == ST_LOCKED) ? own_d[o] : SEL_IDLE;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (state_d[o] == ST_LOCKED && own_d[o] == port_sel_t'(p)) begin
                    gnt_d[p] = 1'b1;
                    dmx_d[p] = port_sel_t'(o);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
                own_q[i]   <= SEL_IDLE;
                rr_q[i]    <= '0;
                mux_q[i]   <= SEL_IDLE;
                dmx_q[i]   <= SEL_IDLE;
            end
            gnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
                own_q[i]   <= own_d[i];
                rr_q[i]    <= rr_d[i];
                mux_q[i]   <= mux_d[i];
                dmx_q[i]   <= dmx_d[i];
            end
            gnt_q <= gnt_d;
        end
    end

`ifdef SW_ALLOC_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
            to_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            to_q <= to_d;
        end
    end

    assign timeout_o = to_q;
`else
    assign timeout_o = '0;
`endif

    assign grant_o = gnt_q;
    assign xfer_o  = xfer;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_sel
        assign sel_mux_o[3*i +: 3]   = mux_q[i];
        assign sel_demux_o[3*i +: 3] = dmx_q[i];
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: expected outputs are queued as each
// cycle's stimulus is driven and popped/compared at the following negedge.
module tb_switch_allocator;

`ifdef SW_ALLOC_TIMEOUT_EN
    localparam int TCYC  = 8;
    localparam int STALL = 6;
`else
    localparam int TCYC  = 64;
    localparam int STALL = 10;
`endif

    localparam logic [14:0] IDLE = 15'h7fff;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [4:0]  req_i;
    logic [14:0] dest_i;
    logic [4:0]  tail_i;
    logic [4:0]  out_ready_i;
    logic [4:0]  grant_o;
    logic [4:0]  xfer_o;
    logic [14:0] sel_demux_o;
    logic [14:0] sel_mux_o;
    logic [4:0]  timeout_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        int          sig;
        logic [14:0] exp;
    } exp_t;

    exp_t sb[$];

    switch_allocator #(
        .NUM_PORTS   (5),
        .TIMEOUT_CYC (TCYC)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .dest_i      (dest_i),
        .tail_i      (tail_i),
        .out_ready_i (out_ready_i),
        .grant_o     (grant_o),
        .xfer_o      (xfer_o),
        .sel_demux_o (sel_demux_o),
        .sel_mux_o   (sel_mux_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [14:0] obs(input int sig);
        case (sig)
            0:       return {10'd0, grant_o};
            1:       return {10'd0, xfer_o};
            2:       return sel_demux_o;
            3:       return sel_mux_o;
            default: return {10'd0, timeout_o};
        endcase
    endfunction

    function automatic logic [14:0] selset(input logic [14:0] base,
                                           input int idx,
                                           input logic [2:0] v);
        logic [14:0] r;
        r = base;
        r[3*idx +: 3] = v;
        return r;
    endfunction

    task automatic expect_all(input string tag, input logic [4:0] g,
                              input logic [4:0] x, input logic [14:0] dm,
                              input logic [14:0] mx, input logic [4:0] to);
        sb.push_back('{{tag, ".grant"}, 0, {10'd0, g}});
        sb.push_back('{{tag, ".xfer"}, 1, {10'd0, x}});
        sb.push_back('{{tag, ".demux"}, 2, dm});
        sb.push_back('{{tag, ".mux"}, 3, mx});
        sb.push_back('{{tag, ".timeout"}, 4, {10'd0, to}});
    endtask

    task automatic cyc();
        exp_t        e;
        logic [14:0] o;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sig);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [4:0] pend;
    int         p;

    initial begin
        rst_ni      = 1'b0;
        req_i       = 5'b00001;
        dest_i      = 15'b000_000_000_000_100;
        tail_i      = 5'b00000;
        out_ready_i = 5'b11111;
        repeat (2) @(posedge clk);
        #1;

        // Held in reset with a live request
        expect_all("reset", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        rst_ni = 1'b1;
        req_i  = 5'b0;
        expect_all("idle", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();

        // Single-flit packet N -> L
        req_i  = 5'b00001;
        dest_i = 15'b000_000_000_000_100;
        tail_i = 5'b00001;
        expect_all("single.req", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        expect_all("single.lock", 5'b00001, 5'b00001,
                   selset(IDLE, 0, 3'd4), selset(IDLE, 4, 3'd0), 5'b0);
        cyc();
        req_i  = 5'b0;
        tail_i = 5'b0;
        expect_all("single.rel", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();

        // S, W, E contend for N with 3-flit packets
        dest_i = 15'b0;
        pend   = 5'b01110;
        for (int k = 0; k < 3; k++) begin
            p      = k + 1;
            req_i  = pend;
            tail_i = 5'b0;
            expect_all("rr.bubble", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
            cyc();
            for (int f = 0; f < 3; f++) begin
                tail_i = (f == 2) ? (5'b1 << p) : 5'b0;
                expect_all("rr.pkt", 5'b1 << p, 5'b1 << p,
                           selset(IDLE, p, 3'd0),
                           selset(IDLE, 0, 3'(p)), 5'b0);
                cyc();
            end
            pend[p] = 1'b0;
        end

        // Pointer now at L: L beats S for N
        req_i  = 5'b10010;
        tail_i = 5'b10010;
        expect_all("rr.ptr.arb", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        expect_all("rr.ptr.win", 5'b10000, 5'b10000,
                   selset(IDLE, 4, 3'd0), selset(IDLE, 0, 3'd4), 5'b0);
        cyc();
        req_i  = 5'b0;
        tail_i = 5'b0;
        expect_all("rr.ptr.rel", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();

        // L -> E with downstream stalled; dest change while locked ignored
        req_i       = 5'b10000;
        dest_i      = 15'b011_000_000_000_000;
        out_ready_i = 5'b10111;
        expect_all("stall.req", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        for (int i = 0; i < STALL; i++) begin
            if (i == 3) begin
                dest_i = 15'b0;
            end
            expect_all("stall.hold", 5'b10000, 5'b0,
                       selset(IDLE, 4, 3'd3), selset(IDLE, 3, 3'd4), 5'b0);
            cyc();
        end
        out_ready_i = 5'b11111;
        expect_all("stall.f1", 5'b10000, 5'b10000,
                   selset(IDLE, 4, 3'd3), selset(IDLE, 3, 3'd4), 5'b0);
        cyc();
        tail_i = 5'b10000;
        expect_all("stall.f2", 5'b10000, 5'b10000,
                   selset(IDLE, 4, 3'd3), selset(IDLE, 3, 3'd4), 5'b0);
        cyc();
        req_i  = 5'b0;
        tail_i = 5'b0;
        expect_all("stall.rel", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();

        // N->E and S->W win together; W->W and E->101 never granted
        req_i  = 5'b01111;
        dest_i = 15'b000_101_010_010_011;
        tail_i = 5'b01111;
        expect_all("par.req", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        expect_all("par.win", 5'b00011, 5'b00011,
                   selset(selset(IDLE, 0, 3'd3), 1, 3'd2),
                   selset(selset(IDLE, 3, 3'd0), 2, 3'd1), 5'b0);
        cyc();
        req_i = 5'b01100;
        for (int i = 0; i < 3; i++) begin
            expect_all("bad.dest", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
            cyc();
        end

        // Reset in the middle of a packet drops the lock
        req_i  = 5'b00001;
        dest_i = 15'b000_000_000_000_100;
        tail_i = 5'b0;
        expect_all("mid.req", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        expect_all("mid.lock", 5'b00001, 5'b00001,
                   selset(IDLE, 0, 3'd4), selset(IDLE, 4, 3'd0), 5'b0);
        cyc();
        rst_ni = 1'b0;
        cyc();
        expect_all("mid.rst", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        rst_ni = 1'b1;
        req_i  = 5'b0;
        expect_all("mid.after", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();

`ifdef SW_ALLOC_TIMEOUT_EN
        // N -> S stalls until the force-release
        req_i       = 5'b00001;
        dest_i      = 15'b000_000_000_000_001;
        tail_i      = 5'b0;
        out_ready_i = 5'b11101;
        expect_all("to.req", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
        for (int i = 0; i < TCYC; i++) begin
            expect_all("to.stall", 5'b00001, 5'b0,
                       selset(IDLE, 0, 3'd1), selset(IDLE, 1, 3'd0), 5'b0);
            cyc();
        end
        req_i = 5'b0;
        expect_all("to.pulse", 5'b0, 5'b0, IDLE, IDLE, 5'b00010);
        cyc();
        out_ready_i = 5'b11111;
        expect_all("to.clear", 5'b0, 5'b0, IDLE, IDLE, 5'b0);
        cyc();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
